// File: rtl/pool_2d_stream.sv
// Streaming KER_SIZE x KER_SIZE pooling over NFMAPS signed lanes: signed max per window,
// or signed floor-average when POOL_AVG_EN is defined (otherwise max only, mode ignored).
module pool_2d_stream #(
    parameter int NBITS    = 32,
    parameter int NFMAPS   = 32,
    parameter int KER_SIZE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NBITS*NFMAPS-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NBITS*NFMAPS-1:0] out_data,
    output logic                    busy
);

    localparam int W  = KER_SIZE * KER_SIZE;
    localparam int LW = $clog2(W);
    localparam int CW = (LW > 0) ? LW : 1;
`ifdef POOL_AVG_EN
    localparam int AW = NBITS + LW;
`else
    localparam int AW = NBITS;
`endif

    // Handshakes: a beat transfers on a rising edge where valid && ready are both 1;
    // valid never waits on ready, and data is held stable while valid && !ready.

    logic [CW-1:0]             cnt_q, cnt_d;
    logic signed [AW-1:0]      acc_q [NFMAPS];
    logic signed [AW-1:0]      acc_d [NFMAPS];
    logic [NBITS*NFMAPS-1:0]   out_q, out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;

    logic                      first;
    logic                      last;
    logic                      take;
    logic signed [AW-1:0]      lane_ext [NFMAPS];
    logic signed [AW-1:0]      max_v    [NFMAPS];
    logic signed [AW-1:0]      acc_nxt  [NFMAPS];
    logic [NBITS-1:0]          lane_res [NFMAPS];
    logic [NBITS*NFMAPS-1:0]   res_vec;

`ifdef POOL_AVG_EN
    logic                      mode_q, mode_d;
    logic                      cur_mode;
    logic signed [AW-1:0]      sum_v [NFMAPS];

    // The first beat's mode governs the whole window, including a W=1 window.
    assign cur_mode = first ? mode : mode_q;
`else
    logic                      unused_mode;

    assign unused_mode = mode;
`endif

    assign first     = (cnt_q == '0);
    assign last      = (cnt_q == CW'(W - 1));
    assign in_ready  = !last || !out_valid_q || out_ready;
    assign take      = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign busy      = busy_q;

    always_comb begin
        res_vec = '0;
        for (int i = 0; i < NFMAPS; i++) begin
            lane_ext[i] = AW'($signed(in_data[i*NBITS +: NBITS]));
            max_v[i]    = (first || (lane_ext[i] > acc_q[i])) ? lane_ext[i] : acc_q[i];
`ifdef POOL_AVG_EN
            sum_v[i]    = first ? lane_ext[i] : acc_q[i] + lane_ext[i];
            acc_nxt[i]  = cur_mode ? sum_v[i] : max_v[i];
            // Arithmetic shift floors toward negative infinity.
            lane_res[i] = cur_mode ? NBITS'(sum_v[i] >>> LW) : NBITS'(max_v[i]);
`else
            acc_nxt[i]  = max_v[i];
            lane_res[i] = NBITS'(max_v[i]);
`endif
            res_vec[i*NBITS +: NBITS] = lane_res[i];
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
`ifdef POOL_AVG_EN
        mode_d      = mode_q;
`endif
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // A beat arriving with flush is dropped together with the partial window.
        if (flush) begin
            cnt_d = '0;
        end else if (take) begin
            acc_d = acc_nxt;
`ifdef POOL_AVG_EN
            if (first) begin
                mode_d = mode;
            end
`endif
            if (last) begin
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_d       = res_vec;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NFMAPS; i++) begin
                acc_q[i] <= '0;
            end
`ifdef POOL_AVG_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            acc_q       <= acc_d;
`ifdef POOL_AVG_EN
            mode_q      <= mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_pool_2d_stream.sv
// Bench for pool_2d_stream (NBITS=8, NFMAPS=2, KER_SIZE=2): directed scenarios plus random
// traffic, scored against a window-level reference model; honours POOL_AVG_EN if defined.
module tb_pool_2d_stream;

    localparam int NBITS    = 8;
    localparam int NFMAPS   = 2;
    localparam int KER_SIZE = 2;
    localparam int WIN      = KER_SIZE * KER_SIZE;
`ifdef POOL_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    flush = 1'b0;
    logic                    mode = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b1;
    logic [NBITS*NFMAPS-1:0] in_data = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic [NBITS*NFMAPS-1:0] out_data;
    logic                    busy;

    pool_2d_stream #(.NBITS(NBITS), .NFMAPS(NFMAPS), .KER_SIZE(KER_SIZE)) dut (
        .clk(clk), .rst(rst), .flush(flush), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [15:0]      exp_q[$];
    int               win_l0[WIN];
    int               win_l1[WIN];
    int               win_n = 0;
    logic             win_mode = 1'b0;
    logic             prev_hold = 1'b0;
    logic [15:0]      prev_data = '0;
    logic             rand_bp = 1'b0;
    int               last_wait = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [7:0] ref_lane(input int v[WIN], input logic avg);
        int best;
        int sum;
        best = v[0];
        sum  = 0;
        for (int i = 0; i < WIN; i++) begin
            if (v[i] > best) best = v[i];
            sum += v[i];
        end
        return avg ? 8'(floor_div(sum, WIN)) : 8'(best);
    endfunction

    // Reference model: collects accepted beats into windows, scores outputs as they leave.
    always @(negedge clk) begin
        if (rst) begin
            win_n = 0;
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            check_eq("busy", busy, win_n != 0);
            check_eq("out_valid", out_valid, exp_q.size() != 0);
            if (prev_hold) check_eq("hold_stable", out_data, prev_data);
            if (out_valid && exp_q.size() != 0) begin
                check_eq("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (flush) begin
                win_n = 0;
            end else if (in_valid && in_ready) begin
                if (win_n == 0) win_mode = AVG_EN ? mode : 1'b0;
                win_l0[win_n] = $signed(in_data[7:0]);
                win_l1[win_n] = $signed(in_data[15:8]);
                win_n++;
                if (win_n == WIN) begin
                    exp_q.push_back({ref_lane(win_l1, win_mode), ref_lane(win_l0, win_mode)});
                    win_n = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [7:0] l0, input logic [7:0] l1, input logic m, input logic fl);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = {l1, l0};
        mode     = m;
        flush    = fl;
        forever begin
            @(negedge clk);
            if (in_ready || fl) break;
            waited++;
            if (waited > 200) begin
                check_eq("accept_timeout", in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        last_wait = waited;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Max window
        send(8'd3, 8'(-8), 1'b0, 1'b0);
        send(8'(-5), 8'(-2), 1'b0, 1'b0);
        send(8'd7, 8'(-3), 1'b0, 1'b0);
        send(8'd1, 8'(-128), 1'b0, 1'b0);
        check_eq("max_latency", out_valid, 1);
        check_eq("max_result", out_data, 16'hFE07);

        // Average window
        send(8'd3, 8'(-1), 1'b1, 1'b0);
        send(8'(-5), 8'(-2), 1'b1, 1'b0);
        send(8'd7, 8'd0, 1'b1, 1'b0);
        send(8'd1, 8'd0, 1'b1, 1'b0);
        check_eq("avg_result", out_data, AVG_EN ? 16'hFF01 : 16'h0007);

        // Mode is latched on the first beat only
        send(8'd4, 8'd0, 1'b1, 1'b0);
        send(8'd4, 8'd0, 1'b0, 1'b0);
        send(8'd4, 8'd0, 1'b0, 1'b0);
        send(8'd8, 8'd0, 1'b0, 1'b0);
        check_eq("mode_latch", out_data, AVG_EN ? 16'h0005 : 16'h0008);

        // Flush on beat 2 discards the partial window
        send(8'd9, 8'd9, 1'b0, 1'b0);
        check_eq("flush_busy_pre", busy, 1);
        send(8'd100, 8'd100, 1'b0, 1'b1);
        check_eq("flush_busy_post", busy, 0);
        for (int i = 1; i <= 4; i++) send(8'(i), 8'(i), 1'b0, 1'b0);
        check_eq("flush_result", out_data, 16'h0404);

        // Backpressure: two windows with out_ready held low
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 8'(i + 4), 1'b0, 1'b0);
        check_eq("bp_first_valid", out_valid, 1);
        for (int i = 1; i <= 3; i++) begin
            send(8'(-10 * i), 8'd0, 1'b0, 1'b0);
            check_eq("bp_no_stall", last_wait, 0);
        end
        in_valid = 1'b1;
        in_data  = {8'd0, 8'(-40)};
        mode     = 1'b0;
        @(negedge clk);
        check_eq("bp_ready_low", in_ready, 0);
        check_eq("bp_result1", out_data, 16'h0804);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("bp_ready_low2", in_ready, 0);
        check_eq("bp_hold1", out_data, 16'h0804);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_ready_high", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("bp_valid_cont", out_valid, 1);
        check_eq("bp_result2", out_data, 16'h00F6);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-window while holding an output
        out_ready = 1'b0;
        for (int i = 5; i <= 8; i++) send(8'(i), 8'(-i), 1'b0, 1'b0);
        send(8'd50, 8'd50, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_out_data", out_data, 0);
        check_eq("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'd1, 8'(-7), 1'b0, 1'b0);
        send(8'(-3), 8'(-6), 1'b0, 1'b0);
        send(8'd2, 8'(-9), 1'b0, 1'b0);
        send(8'd0, 8'(-100), 1'b0, 1'b0);
        check_eq("arst_next_result", out_data, 16'hFA02);

        // Random traffic with random backpressure, mode and occasional flush
        rand_bp = 1'b1;
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("drain_queue", exp_q.size(), 0);
        check_eq("drain_valid", out_valid, 0);
        check_eq("drain_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
